// File: rtl/mips_processor.sv
// rtl/mips_processor.sv - single-cycle 32-bit MIPS-subset CPU with internal memories
//
// mips_imem      : instruction store, combinational read; contents are loaded by the bench
//                  ports: addr (word index) -> data (instruction word)
// mips_reg_file  : 32 x 32-bit registers, two combinational reads, one clocked write, $0 fixed at 0
//                  ports: clk, reset, ra1/ra2 -> rd1/rd2, we/wa/wd write port
// mips_processor : top; fetch, decode, ALU, data memory and next-PC in one cycle
//                  ports: clk, reset (synchronous, active-high)

module mips_imem #(
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic [AW-1:0] addr,
    output logic [31:0]   data
);
    logic [31:0] memory [0:WORDS-1];

    assign data = memory[addr];
endmodule

module mips_reg_file (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] registers [0:31];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) registers[i] <= '0;
        end else if (we && wa != 5'd0) begin
            registers[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : registers[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : registers[ra2];
endmodule

module mips_processor #(
    parameter int IMEM_WORDS = 1024,
    parameter int DMEM_WORDS = 1024
) (
    input logic clk,
    input logic reset
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    logic [31:0] pc_reg;
    logic [31:0] instruction;

    mips_imem #(.WORDS(IMEM_WORDS)) imem (
        .addr (pc_reg[IAW+1:2]),
        .data (instruction)
    );

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] sext_imm, zext_imm;

    assign opcode   = instruction[31:26];
    assign rs       = instruction[25:21];
    assign rt       = instruction[20:16];
    assign rd       = instruction[15:11];
    assign shamt    = instruction[10:6];
    assign funct    = instruction[5:0];
    assign imm      = instruction[15:0];
    assign sext_imm = {{16{imm[15]}}, imm};
    assign zext_imm = {16'd0, imm};

    logic [31:0] rs_val, rt_val, write_data;
    logic [4:0]  write_reg;
    logic        reg_write;

    mips_reg_file REG_FILE (
        .clk   (clk),
        .reset (reset),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (rs_val),
        .rd2   (rt_val),
        .we    (reg_write),
        .wa    (write_reg),
        .wd    (write_data)
    );

    logic [31:0] dmem [0:DMEM_WORDS-1];
    logic [31:0] alu_result, mem_rdata, pc_plus4, branch_target, next_pc;
    logic        mem_write, mem_to_reg;

    assign pc_plus4      = pc_reg + 32'd4;
    assign branch_target = pc_plus4 + {sext_imm[29:0], 2'b00};
    assign mem_rdata     = dmem[alu_result[DAW+1:2]];
    assign write_data    = mem_to_reg ? mem_rdata : alu_result;

    // Decode and execute; anything unrecognised leaves every write enable low.
    always_comb begin
        alu_result = '0;
        reg_write  = 1'b0;
        write_reg  = rt;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        next_pc    = pc_plus4;
        case (opcode)
            OP_RTYPE: begin
                write_reg = rd;
                reg_write = 1'b1;
                case (funct)
                    FN_ADD:  alu_result = rs_val + rt_val;
                    FN_SUB:  alu_result = rs_val - rt_val;
                    FN_AND:  alu_result = rs_val & rt_val;
                    FN_OR:   alu_result = rs_val | rt_val;
                    FN_NOR:  alu_result = ~(rs_val | rt_val);
                    FN_SLT:  alu_result = {31'd0, $signed(rs_val) < $signed(rt_val)};
                    FN_SLL:  alu_result = rt_val << shamt;
                    FN_SRL:  alu_result = rt_val >> shamt;
                    FN_SRA:  alu_result = $unsigned($signed(rt_val) >>> shamt);
                    default: reg_write = 1'b0;
                endcase
            end
            OP_ADDI: begin alu_result = rs_val + sext_imm; reg_write = 1'b1; end
            OP_ANDI: begin alu_result = rs_val & zext_imm; reg_write = 1'b1; end
            OP_ORI:  begin alu_result = rs_val | zext_imm; reg_write = 1'b1; end
            OP_LUI:  begin alu_result = {imm, 16'd0};      reg_write = 1'b1; end
            OP_SLTI: begin
                alu_result = {31'd0, $signed(rs_val) < $signed(sext_imm)};
                reg_write  = 1'b1;
            end
            OP_LW: begin
                alu_result = rs_val + sext_imm;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            OP_SW: begin
                alu_result = rs_val + sext_imm;
                mem_write  = 1'b1;
            end
            OP_BEQ:  if (rs_val == rt_val) next_pc = branch_target;
            OP_BNE:  if (rs_val != rt_val) next_pc = branch_target;
            OP_J:    next_pc = {pc_plus4[31:28], instruction[25:0], 2'b00};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg <= '0;
            for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= '0;
        end else begin
            pc_reg <= next_pc;
            if (mem_write) dmem[alu_result[DAW+1:2]] <= rt_val;
        end
    end
endmodule

// File: tb/tb_mips_processor.sv
// tb/tb_mips_processor.sv - randomized self-checking bench for mips_processor against an ISA model
module tb_mips_processor;
    logic clk;
    logic reset;

    mips_processor dut (
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_imem [0:1023];
    logic [31:0] m_mem  [0:1023];
    logic [31:0] m_regs [0:31];
    logic [31:0] m_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_word(input int idx, input logic [31:0] w);
        m_imem[idx] = w;
        dut.imem.memory[idx] = w;
    endtask

    task automatic model_reset();
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        for (int i = 0; i < 1024; i++) m_mem[i] = 32'd0;
    endtask

    // Instruction-set level reference: one call retires one instruction.
    task automatic model_step();
        logic [31:0] ins, a, b, se, npc, res;
        logic [5:0]  op, fn;
        logic [4:0]  dst;
        logic        wr;
        ins = m_imem[m_pc[11:2]];
        op  = ins[31:26];
        fn  = ins[5:0];
        a   = m_regs[ins[25:21]];
        b   = m_regs[ins[20:16]];
        se  = {{16{ins[15]}}, ins[15:0]};
        npc = m_pc + 32'd4;
        wr  = 1'b1;
        dst = ins[20:16];
        res = 32'd0;
        case (op)
            6'd0: begin
                dst = ins[15:11];
                case (fn)
                    6'h20: res = a + b;
                    6'h22: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h27: res = ~(a | b);
                    6'h2a: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h00: res = b << ins[10:6];
                    6'h02: res = b >> ins[10:6];
                    6'h03: res = $unsigned($signed(b) >>> ins[10:6]);
                    default: wr = 1'b0;
                endcase
            end
            6'h08: res = a + se;
            6'h0c: res = a & {16'd0, ins[15:0]};
            6'h0d: res = a | {16'd0, ins[15:0]};
            6'h0f: res = {ins[15:0], 16'd0};
            6'h0a: res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
            6'h23: begin res = a + se; res = m_mem[res[11:2]]; end
            6'h2b: begin res = a + se; m_mem[res[11:2]] = b; wr = 1'b0; end
            6'h04: begin wr = 1'b0; if (a == b) npc = npc + (se << 2); end
            6'h05: begin wr = 1'b0; if (a != b) npc = npc + (se << 2); end
            6'h02: begin wr = 1'b0; npc = {npc[31:28], ins[25:0], 2'b00}; end
            default: wr = 1'b0;
        endcase
        if (wr) m_regs[dst] = res;
        m_regs[0] = 32'd0;
        m_pc = npc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_state();
        check("pc", dut.pc_reg, m_pc);
        for (int r = 0; r < 32; r++)
            check($sformatf("r%0d", r), dut.REG_FILE.registers[r], m_regs[r]);
    endtask

    function automatic logic [31:0] r_type(input int s, input int t, input int d, input int sh, input logic [5:0] fn);
        r_type = {6'd0, 5'(s), 5'(t), 5'(d), 5'(sh), fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input int s, input int t, input logic [15:0] im);
        i_type = {op, 5'(s), 5'(t), im};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] ft [0:8];
        logic [15:0] im;
        int s, t, d, k, off;
        ft = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h00, 6'h02, 6'h03};
        s  = $urandom_range(0, 7);
        t  = $urandom_range(0, 7);
        d  = $urandom_range(0, 7);
        im = 16'($urandom);
        off = int'($urandom_range(0, 16)) - 8;
        k  = $urandom_range(0, 22);
        case (k)
            9:  rand_instr = i_type(6'h08, s, t, im);
            10: rand_instr = i_type(6'h0c, s, t, im);
            11: rand_instr = i_type(6'h0d, s, t, im);
            12: rand_instr = i_type(6'h0f, s, t, im);
            13: rand_instr = i_type(6'h0a, s, t, im);
            14: rand_instr = i_type(6'h23, s, t, im);
            15: rand_instr = i_type(6'h2b, s, t, im);
            16: rand_instr = i_type(6'h04, s, t, off[15:0]);
            17: rand_instr = i_type(6'h05, s, t, off[15:0]);
            18: rand_instr = {6'h02, 26'($urandom_range(0, 1023))};
            19: rand_instr = i_type(6'h3f, s, t, im);
            20: rand_instr = r_type(s, t, d, 0, 6'h3f);
            21: rand_instr = i_type(6'h08, s, t, 16'($urandom_range(0, 40)));
            22: rand_instr = i_type(6'h08, s, t, 16'($urandom_range(0, 40)));
            default: rand_instr = r_type(s, t, d, $urandom_range(0, 31), ft[k]);
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 1024; i++) load_word(i, 32'd0);
        load_word(0,  i_type(6'h08, 0, 1, 16'd10));
        load_word(1,  i_type(6'h08, 0, 2, 16'd20));
        load_word(2,  r_type(1, 2, 3, 0, 6'h20));
        load_word(3,  i_type(6'h2b, 0, 3, 16'd8));
        load_word(4,  i_type(6'h23, 0, 4, 16'd8));
        load_word(5,  i_type(6'h04, 4, 3, 16'd2));
        load_word(6,  r_type(4, 3, 5, 0, 6'h22));
        load_word(7,  {6'h02, 26'd9});
        load_word(8,  r_type(4, 1, 4, 0, 6'h25));
        load_word(9,  r_type(1, 4, 6, 0, 6'h2a));
        load_word(10, r_type(4, 6, 7, 0, 6'h27));
        load_word(11, i_type(6'h0c, 1, 8, 16'd5));
        load_word(12, i_type(6'h0d, 1, 9, 16'd15));
        load_word(13, i_type(6'h0f, 0, 10, 16'hffff));
        load_word(14, i_type(6'h0a, 5, 11, 16'd2));
        load_word(15, i_type(6'h05, 1, 1, 16'd3));
        load_word(16, i_type(6'h08, 0, 0, 16'd5));
        load_word(17, {6'h02, 26'd19});
        load_word(18, i_type(6'h08, 0, 12, 16'd1));
        load_word(19, i_type(6'h0f, 0, 13, 16'h8000));
        load_word(20, r_type(0, 13, 14, 4, 6'h00));
        load_word(21, r_type(0, 13, 15, 4, 6'h02));
        load_word(22, r_type(0, 13, 16, 4, 6'h03));
        load_word(23, i_type(6'h3f, 1, 1, 16'h1234));
        load_word(24, r_type(1, 1, 1, 0, 6'h3f));

        tick();
        tick();
        check("reset_pc", dut.pc_reg, 32'd0);
        for (int r = 1; r < 8; r++)
            check($sformatf("reset_r%0d", r), dut.REG_FILE.registers[r], 32'd0);
        check("reset_dmem2", dut.dmem[2], 32'd0);
        reset = 1'b0;
        model_reset();

        for (int c = 1; c <= 22; c++) begin
            tick();
            model_step();
            compare_state();
            if (c == 6)  check("beq_taken_pc", dut.pc_reg, 32'd32);
            if (c == 14) check("bne_not_taken_pc", dut.pc_reg, 32'd64);
            if (c == 16) check("j_pc", dut.pc_reg, 32'd76);
        end
        check("dir_r1", dut.REG_FILE.registers[1], 32'd10);
        check("dir_r2", dut.REG_FILE.registers[2], 32'd20);
        check("dir_r3", dut.REG_FILE.registers[3], 32'd30);
        check("dir_dmem2", dut.dmem[2], 32'd30);
        check("dir_r4", dut.REG_FILE.registers[4], 32'd30);
        check("dir_r5_skipped", dut.REG_FILE.registers[5], 32'd0);
        check("dir_slt", dut.REG_FILE.registers[6], 32'd1);
        check("dir_nor", dut.REG_FILE.registers[7], 32'hffffffe0);
        check("dir_andi", dut.REG_FILE.registers[8], 32'd0);
        check("dir_ori", dut.REG_FILE.registers[9], 32'd15);
        check("dir_lui", dut.REG_FILE.registers[10], 32'hffff0000);
        check("dir_slti", dut.REG_FILE.registers[11], 32'd1);
        check("dir_r0", dut.REG_FILE.registers[0], 32'd0);
        check("dir_j_skip", dut.REG_FILE.registers[12], 32'd0);
        check("dir_sll", dut.REG_FILE.registers[14], 32'd0);
        check("dir_srl", dut.REG_FILE.registers[15], 32'h08000000);
        check("dir_sra", dut.REG_FILE.registers[16], 32'hf8000000);
        check("dir_nop_pc", dut.pc_reg, 32'd100);

        reset = 1'b1;
        for (int i = 0; i < 1024; i++) load_word(i, rand_instr());
        tick();
        model_reset();
        reset = 1'b0;
        compare_state();
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) reset = 1'b1;
            tick();
            if (reset) begin
                model_reset();
                reset = 1'b0;
            end else begin
                model_step();
            end
            compare_state();
        end
        for (int i = 0; i < 1024; i++)
            check($sformatf("dmem%0d", i), dut.dmem[i], m_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
